sl_receiver_fifo: RTL and testbench

// Parametrised next-generation serial-line (SL) receiver. It decodes the two-wire SL code:
//   - idle is both lines high; each bit is one line pulled low, then both return high.
//   - zeroes line low = 0, ones line low = 1, both low = stop.

---
 rtl/sl_receiver_fifo_if.sv | 24 ++
 rtl/sl_receiver_fifo.sv | 279 +++++++++++++++++++++++++++
 tb/tb_sl_receiver_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sl_receiver_fifo_if.sv
// sl_receiver_fifo_if: word FIFO read port (valid/ready).
// master drives m_data/m_err/m_valid; slave drives m_ready.
interface sl_receiver_fifo_if #(
  parameter int MAX_BITS = 32
);
  logic [MAX_BITS-1:0] m_data;
  logic [2:0]          m_err;
  logic                m_valid;
  logic                m_ready;

  modport master (
    output m_data,
    output m_err,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_err,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/sl_receiver_fifo.sv
// sl_receiver_fifo: two-wire SL decoder feeding a FWFT word FIFO.
// Ports: clk, rst (sync, high), serial_line_zeroes_a/ones_a (async
// lines), cfg_bit_cnt/cfg_parity_en (latched on first bit), ovf_clr,
// m (word read port: m_data, m_err {LEV,PAR,LEN}, m_valid, m_ready),
// fifo_level, busy, ovf (sticky drop flag).
module sl_receiver_fifo #(
  parameter int MAX_BITS    = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int STROB_POS   = 8,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_line_zeroes_a,
  input  logic                          serial_line_ones_a,
  input  logic [5:0]                    cfg_bit_cnt,
  input  logic                          cfg_parity_en,
  input  logic                          ovf_clr,
  sl_receiver_fifo_if.master            m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          ovf
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = MAX_BITS + 3;
  localparam int CMAX = (TIMEOUT > 2 * STROB_POS) ?
                        TIMEOUT : 2 * STROB_POS;
  localparam int CW   = $clog2(CMAX + 2);

  localparam logic [CW-1:0] C_STROB = CW'(STROB_POS);
  localparam logic [CW-1:0] C_TMO   = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_REC   = CW'(2 * STROB_POS - 1);
  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] E_LEV = 3'b100;
  localparam logic [2:0] E_PAR = 3'b010;
  localparam logic [2:0] E_LEN = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    BIT_CNT,
    BIT_END,
    PUSH,
    RECOVER
  } state_e;

  // synchronisers
  logic [SYNC_STAGES-1:0] sz_q, sz_d;
  logic [SYNC_STAGES-1:0] so_q, so_d;
  logic                   s0, s1, hi;

  always_comb begin
    sz_d = {sz_q[SYNC_STAGES-2:0], serial_line_zeroes_a};
    so_d = {so_q[SYNC_STAGES-2:0], serial_line_ones_a};
  end

  assign s0 = sz_q[SYNC_STAGES-1];
  assign s1 = so_q[SYNC_STAGES-1];
  assign hi = s1 & s0;

  // decoder state
  state_e              state_q, state_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [5:0]          bits_q, bits_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [2:0]          err_q, err_d;
  logic                par_q, par_d;
  logic                pend_q, pend_d;
  logic [5:0]          cfg_bits_q, cfg_bits_d;
  logic                cfg_par_q, cfg_par_d;
  logic                hi_q, hi_d;
  logic                push_req;

  logic [6:0] exp_bits;
  logic [6:0] bits7;
  logic       bit_val;

  assign exp_bits = {1'b0, cfg_bits_q} + {6'b0, cfg_par_q};
  assign bits7    = {1'b0, bits_q};
  assign bit_val  = s0;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bits_d     = bits_q;
    data_d     = data_q;
    err_d      = err_q;
    par_d      = par_q;
    pend_d     = pend_q;
    cfg_bits_d = cfg_bits_q;
    cfg_par_d  = cfg_par_q;
    hi_d       = hi;
    push_req   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // only a fresh falling edge starts a bit
        if (!hi && hi_q) begin
          state_d = BIT_CNT;
          cyc_d   = CW'(1);
          if (bits_q == 6'd0) begin
            cfg_bits_d = cfg_bit_cnt;
            cfg_par_d  = cfg_parity_en;
          end
        end else if (bits_q != 6'd0) begin
          if (cyc_q >= C_TMO) begin
            err_d   = E_LEN;
            state_d = PUSH;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
      end

      BIT_CNT: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == C_STROB) begin
          unique case ({s1, s0})
            2'b10, 2'b01: begin
              if (bits7 >= exp_bits) begin
                err_d   = E_LEN;
                state_d = PUSH;
              end else begin
                if (bits7 < {1'b0, cfg_bits_q}) begin
                  for (int i = 0; i < MAX_BITS; i++) begin
                    if (i == int'(bits_q)) data_d[i] = bit_val;
                  end
                end
                par_d   = par_q ^ bit_val;
                bits_d  = bits_q + 6'd1;
                state_d = BIT_END;
              end
            end
            2'b00: begin
              // clean words push right away; bad ones wait
              // for release so a stuck line can upgrade to LEV
              if (bits7 != exp_bits) begin
                err_d   = E_LEN;
                pend_d  = 1'b1;
                state_d = BIT_END;
              end else if (cfg_par_q && !par_q) begin
                err_d   = E_PAR;
                pend_d  = 1'b1;
                state_d = BIT_END;
              end else begin
                state_d = PUSH;
              end
            end
            2'b11: begin
              err_d   = E_LEV;
              state_d = PUSH;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      BIT_END: begin
        if (hi) begin
          cyc_d   = '0;
          state_d = pend_q ? PUSH : IDLE;
        end else if (cyc_q >= C_TMO) begin
          err_d   = E_LEV;
          state_d = PUSH;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      PUSH: begin
        push_req = 1'b1;
        bits_d   = '0;
        data_d   = '0;
        err_d    = '0;
        par_d    = 1'b0;
        pend_d   = 1'b0;
        cyc_d    = '0;
        state_d  = (err_q != 3'b000) ? RECOVER : IDLE;
      end

      RECOVER: begin
        if (hi) begin
          if (cyc_q == C_REC) begin
            cyc_d   = '0;
            state_d = IDLE;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end else begin
          cyc_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          valid, full, pop, do_push, drop;

  assign valid   = cnt_q != '0;
  assign full    = cnt_q == C_DEPTH;
  assign pop     = valid && m.m_ready;
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = {err_q, data_q};
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q;
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // a drop wins over a simultaneous clear
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  assign m.m_valid  = valid;
  assign m.m_data   = valid ? mem_q[rd_q][MAX_BITS-1:0] : '0;
  assign m.m_err    = valid ? mem_q[rd_q][EW-1:MAX_BITS] : '0;
  assign fifo_level = cnt_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q != IDLE) || (bits_q != 6'd0);

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sz_q       <= '1;
      so_q       <= '1;
      state_q    <= IDLE;
      cyc_q      <= '0;
      bits_q     <= '0;
      data_q     <= '0;
      err_q      <= '0;
      par_q      <= 1'b0;
      pend_q     <= 1'b0;
      cfg_bits_q <= '0;
      cfg_par_q  <= 1'b0;
      hi_q       <= 1'b1;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sz_q       <= sz_d;
      so_q       <= so_d;
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bits_q     <= bits_d;
      data_q     <= data_d;
      err_q      <= err_d;
      par_q      <= par_d;
      pend_q     <= pend_d;
      cfg_bits_q <= cfg_bits_d;
      cfg_par_q  <= cfg_par_d;
      hi_q       <= hi_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sl_receiver_fifo.sv
// tb_sl_receiver_fifo: directed bench for the SL receiver FIFO.
// Bit = 16 cycles low + 16 high; expectations computed by hand.
module tb_sl_receiver_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       zl, ol;
  logic [5:0] cfg_bits;
  logic       cfg_par;
  logic       ovf_clr;
  logic [2:0] lvl;
  logic       busy, ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sl_receiver_fifo_if #(.MAX_BITS(32)) sif ();

  sl_receiver_fifo #(
    .MAX_BITS   (32),
    .FIFO_DEPTH (4),
    .STROB_POS  (8),
    .TIMEOUT    (64),
    .SYNC_STAGES(2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .serial_line_zeroes_a(zl),
    .serial_line_ones_a  (ol),
    .cfg_bit_cnt         (cfg_bits),
    .cfg_parity_en       (cfg_par),
    .ovf_clr             (ovf_clr),
    .m                   (sif),
    .fifo_level          (lvl),
    .busy                (busy),
    .ovf                 (ovf)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0: data 0, 1: data 1, 2: stop
  task automatic sym(input int s);
    zl = !(s == 0 || s == 2);
    ol = !(s == 1 || s == 2);
    tick(16);
    zl = 1'b1;
    ol = 1'b1;
    tick(16);
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) sym(int'(d[i]));
  endtask

  task automatic pop_check(input string tag,
                           input logic [31:0] ed,
                           input logic [2:0] ee);
    int n;
    n = 0;
    while (!sif.m_valid && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_valid"}, 64'(sif.m_valid), 64'd1);
    chk({tag, "_data"}, 64'(sif.m_data), 64'(ed));
    chk({tag, "_err"}, 64'(sif.m_err), 64'(ee));
    sif.m_ready = 1'b1;
    tick(1);
    sif.m_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    zl          = 1'b1;
    ol          = 1'b1;
    cfg_bits    = 6'd8;
    cfg_par     = 1'b1;
    ovf_clr     = 1'b0;
    sif.m_ready = 1'b0;
    tick(3);
    chk("rst_valid", 64'(sif.m_valid), 64'd0);
    chk("rst_level", 64'(lvl), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(sif.m_data), 64'd0);
    chk("rst_err", 64'(sif.m_err), 64'd0);
    rst = 1'b0;
    tick(5);

    // clean 0xA5, odd parity bit 1; valid 2 cycles after strobe
    send_bits(64'hA5, 8);
    sym(1);
    zl = 1'b0;
    ol = 1'b0;
    tick(11);
    chk("clean_valid_early", 64'(sif.m_valid), 64'd0);
    tick(1);
    chk("clean_valid", 64'(sif.m_valid), 64'd1);
    chk("clean_data", 64'(sif.m_data), 64'hA5);
    chk("clean_err", 64'(sif.m_err), 64'd0);
    tick(4);
    zl = 1'b1;
    ol = 1'b1;
    tick(16);
    sif.m_ready = 1'b1;
    tick(1);
    sif.m_ready = 1'b0;
    chk("clean_popped", 64'(lvl), 64'd0);

    // wrong parity
    send_bits(64'hA5, 8);
    sym(0);
    sym(2);
    tick(40);
    pop_check("par", 32'hA5, 3'b010);

    // short word
    cfg_par = 1'b0;
    send_bits(64'h25, 7);
    sym(2);
    tick(40);
    pop_check("len7", 32'h25, 3'b001);

    // long word: LEN at the 9th strobe
    send_bits(64'h1FF, 9);
    tick(40);
    pop_check("len9", 32'hFF, 3'b001);

    // stuck low mid-word, then a clean word
    send_bits(64'h5, 3);
    zl = 1'b0;
    ol = 1'b0;
    tick(80);
    zl = 1'b1;
    ol = 1'b1;
    tick(40);
    pop_check("lev", 32'h5, 3'b100);
    send_bits(64'h96, 8);
    sym(2);
    tick(20);
    pop_check("after_lev", 32'h96, 3'b000);

    // overflow: 5 words into depth 4
    for (int w = 1; w <= 5; w++) begin
      send_bits(64'(w * 8'h11), 8);
      sym(2);
    end
    tick(5);
    chk("ovf_level", 64'(lvl), 64'd4);
    chk("ovf_set", 64'(ovf), 64'd1);
    pop_check("ovf_w1", 32'h11, 3'b000);
    pop_check("ovf_w2", 32'h22, 3'b000);
    pop_check("ovf_w3", 32'h33, 3'b000);
    pop_check("ovf_w4", 32'h44, 3'b000);
    chk("ovf_drained", 64'(lvl), 64'd0);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // reset mid-word discards it
    cfg_bits = 6'd32;
    cfg_par  = 1'b0;
    send_bits(64'hFFFF0001, 10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_level", 64'(lvl), 64'd0);
    cfg_bits = 6'd8;
    cfg_par  = 1'b1;
    tick(10);
    send_bits(64'h3C, 8);
    sym(1);
    sym(2);
    tick(20);
    chk("post_rst_level", 64'(lvl), 64'd1);
    pop_check("post_rst", 32'h3C, 3'b000);
    chk("post_rst_empty", 64'(lvl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
